// File: rtl/video_mem_pkg.sv
// Shared definitions for the video memory painter and the game-logic command issuer.
// Command codes, grid geometry and FSM state encoding.
package video_mem_pkg;

  localparam int GRID_BITS = 6;
  localparam int DATA_W    = 4;
  localparam int ADDR_W    = 2 * GRID_BITS;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_FILL  = 2'b01,
    OP_READ  = 2'b10,
    OP_NOP   = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_FILL     = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_FINISH   = 3'd5
  } state_t;

  // Last covered coordinate, saturated at the grid edge; size must be nonzero.
  function automatic logic [GRID_BITS-1:0] clip_end(
    input logic [GRID_BITS-1:0] start,
    input logic [GRID_BITS-1:0] size
  );
    logic [GRID_BITS:0] sum;
    sum = {1'b0, start} + {1'b0, size} - (GRID_BITS+1)'(1);
    clip_end = sum[GRID_BITS] ? '1 : sum[GRID_BITS-1:0];
  endfunction

endpackage

// File: rtl/video_mem_painter_rect_scanner.sv
// Row-major cell walker over a clipped rectangle.
// Ends are latched on load; full selects the whole 64x64 grid.
module rect_scanner
  import video_mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 full,
  input  logic [GRID_BITS-1:0] x,
  input  logic [GRID_BITS-1:0] y,
  input  logic [GRID_BITS-1:0] w,
  input  logic [GRID_BITS-1:0] h,
  output logic [GRID_BITS-1:0] cur_x,
  output logic [GRID_BITS-1:0] cur_y,
  output logic                 last,
  output logic                 empty
);

  logic [GRID_BITS-1:0] start_x;
  logic [GRID_BITS-1:0] start_y;
  logic [GRID_BITS-1:0] end_x;
  logic [GRID_BITS-1:0] end_y;
  logic [GRID_BITS-1:0] x0_q;
  logic [GRID_BITS-1:0] ex_q;
  logic [GRID_BITS-1:0] ey_q;

  always_comb begin
    start_x = full ? '0 : x;
    start_y = full ? '0 : y;
    end_x   = full ? '1 : clip_end(x, w);
    end_y   = full ? '1 : clip_end(y, h);
    empty   = !full && (w == '0 || h == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_x <= '0;
      cur_y <= '0;
      x0_q  <= '0;
      ex_q  <= '0;
      ey_q  <= '0;
    end else if (load) begin
      cur_x <= start_x;
      cur_y <= start_y;
      x0_q  <= start_x;
      ex_q  <= end_x;
      ey_q  <= end_y;
    end else if (step) begin
      if (cur_x == ex_q) begin
        cur_x <= x0_q;
        cur_y <= cur_y + 1'b1;
      end else begin
        cur_x <= cur_x + 1'b1;
      end
    end
  end

  assign last = (cur_x == ex_q) && (cur_y == ey_q);

endmodule

// File: rtl/video_mem_painter.sv
// Command-driven painter for video memory port B: CLEAR, FILL_RECT, READ_CELL.
// One RAM access per cycle; address/data hold their last value when idle.
module video_mem_painter
  import video_mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [GRID_BITS-1:0] cmd_x,
  input  logic [GRID_BITS-1:0] cmd_y,
  input  logic [GRID_BITS-1:0] cmd_w,
  input  logic [GRID_BITS-1:0] cmd_h,
  input  logic [DATA_W-1:0]    cmd_color,
  output logic                 done,
  output logic                 rd_valid,
  output logic [DATA_W-1:0]    rd_result,
  output logic [ADDR_W-1:0]    wr_video_mem_addr,
  output logic                 wr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 rd,
  input  logic [DATA_W-1:0]    rd_data
);

  state_t               state;
  state_t               state_n;
  op_t                  op_q;
  logic [DATA_W-1:0]    color_q;
  logic [ADDR_W-1:0]    held_addr;
  logic [DATA_W-1:0]    held_data;
  logic [GRID_BITS-1:0] cur_x;
  logic [GRID_BITS-1:0] cur_y;
  logic                 last;
  logic                 empty;
  logic                 accept;
  logic                 is_clear;

  assign accept   = cmd_valid && cmd_ready;
  assign is_clear = (cmd_op == OP_CLEAR);

  rect_scanner u_scan (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .step  (wr),
    .full  (is_clear),
    .x     (cmd_x),
    .y     (cmd_y),
    .w     (cmd_w),
    .h     (cmd_h),
    .cur_x (cur_x),
    .cur_y (cur_y),
    .last  (last),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            cmd_op == OP_CLEAR: state_n = ST_CLEAR;
            cmd_op == OP_FILL:  state_n = empty ? ST_FINISH : ST_FILL;
            cmd_op == OP_READ:  state_n = ST_RD_ISSUE;
            default:            state_n = ST_FINISH;
          endcase
        end
      end
      ST_CLEAR,
      ST_FILL:     if (last) state_n = ST_FINISH;
      ST_RD_ISSUE: state_n = ST_RD_WAIT;
      ST_RD_WAIT:  state_n = ST_FINISH;
      ST_FINISH:   state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    wr        = (state == ST_CLEAR) || (state == ST_FILL);
    rd        = (state == ST_RD_ISSUE);
    done      = (state == ST_FINISH);
    rd_valid  = (state == ST_FINISH) && (op_q == OP_READ);
    wr_video_mem_addr = (wr || rd) ? {cur_y, cur_x} : held_addr;
    wr_data   = wr ? color_q : held_data;
  end

  // Last driven address/data are kept so the RAM port sees stable values when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= OP_NOP;
      color_q   <= '0;
      held_addr <= '0;
      held_data <= '0;
      rd_result <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_t'(cmd_op);
        color_q <= cmd_color;
      end
      if (wr || rd) held_addr <= wr_video_mem_addr;
      if (wr)       held_data <= wr_data;
      if (state == ST_RD_WAIT) rd_result <= rd_data;
    end
  end

endmodule
